// File: rtl/axis_line_drawer_pkg.sv
// rtl/axis_line_drawer_pkg.sv - shared state encoding and direction constants for axis_line_drawer
package axis_line_drawer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic DIR_H = 1'b0;
  localparam logic DIR_V = 1'b1;

endpackage

// File: rtl/axis_line_drawer.sv
// rtl/axis_line_drawer.sv - axis-aligned line pixel generator with ack handshake
// Optional screen clipping enabled by defining AXIS_LINE_DRAWER_CLIP_EN.
module axis_line_drawer
  import axis_line_drawer_pkg::*;
#(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int LEN_W    = 9,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [X_W-1:0]   x_in,
  input  logic [Y_W-1:0]   y_in,
  input  logic [LEN_W-1:0] length,
  input  logic             ack,
  output logic             draw,
  output logic [X_W-1:0]   x_out,
  output logic [Y_W-1:0]   y_out,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nx;
  logic             dir_r;
  logic [X_W-1:0]   x0;
  logic [Y_W-1:0]   y0;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] cnt;

  logic [X_W-1:0]   x_pix;
  logic [Y_W-1:0]   y_pix;
  logic             visible;
  logic             last;
  logic             latch;
  logic             advance;
  logic             draw_c;
  logic             done_c;

  // Sums wrap naturally at the coordinate width.
  assign x_pix = x0 + ((dir_r == DIR_H) ? X_W'(cnt) : '0);
  assign y_pix = y0 + ((dir_r == DIR_V) ? Y_W'(cnt) : '0);
  assign last  = (cnt == len_r - LEN_W'(1));

`ifdef AXIS_LINE_DRAWER_CLIP_EN
  assign visible = (32'(x_pix) < 32'(SCREEN_W)) && (32'(y_pix) < 32'(SCREEN_H));
`else
  logic unused_screen;
  assign unused_screen = ^{32'(SCREEN_W), 32'(SCREEN_H)};
  assign visible       = 1'b1;
`endif

  always_comb begin
    state_nx = state;
    latch    = 1'b0;
    advance  = 1'b0;
    draw_c   = 1'b0;
    done_c   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          latch    = 1'b1;
          state_nx = (length != '0) ? DRAW : DONE;
        end
      end
      DRAW: begin
        draw_c  = visible;
        // Off-screen pixels are skipped one per cycle without a handshake.
        advance = visible ? ack : 1'b1;
        if (advance && last) state_nx = DONE;
      end
      DONE: begin
        done_c = 1'b1;
        if (!start) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      dir_r <= 1'b0;
      x0    <= '0;
      y0    <= '0;
      len_r <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (latch) begin
        dir_r <= dir;
        x0    <= x_in;
        y0    <= y_in;
        len_r <= length;
        cnt   <= '0;
      end else if (advance) begin
        cnt <= cnt + LEN_W'(1);
      end
    end
  end

  // Gating with reset keeps outputs quiet during the reset cycle itself.
  assign draw  = draw_c && !reset;
  assign done  = done_c && !reset;
  assign busy  = (state != IDLE) && !reset;
  assign x_out = draw ? x_pix : '0;
  assign y_out = draw ? y_pix : '0;

endmodule

// File: tb/tb_axis_line_drawer.sv
// tb/tb_axis_line_drawer.sv - self-checking bench for axis_line_drawer
module tb_axis_line_drawer;

  localparam int X_W      = 9;
  localparam int Y_W      = 8;
  localparam int LEN_W    = 9;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
`ifdef AXIS_LINE_DRAWER_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             dir;
  logic [X_W-1:0]   x_in;
  logic [Y_W-1:0]   y_in;
  logic [LEN_W-1:0] length;
  logic             ack;
  logic             draw;
  logic [X_W-1:0]   x_out;
  logic [Y_W-1:0]   y_out;
  logic             busy;
  logic             done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  axis_line_drawer #(
    .X_W(X_W), .Y_W(Y_W), .LEN_W(LEN_W), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir), .x_in(x_in), .y_in(y_in),
    .length(length), .ack(ack), .draw(draw), .x_out(x_out), .y_out(y_out),
    .busy(busy), .done(done)
  );

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; dir = 1'b0; x_in = 9'd33; y_in = 8'd44;
    length = 9'd5; ack = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({draw, done, busy, x_out, y_out} !== '0) begin
      fails++;
      $display("FAIL reset_during: draw=%0b done=%0b busy=%0b x=%0d y=%0d, want all 0",
               draw, done, busy, x_out, y_out);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    tests++;
    if ({draw, done, busy, x_out, y_out} !== '0) begin
      fails++;
      $display("FAIL reset_after: draw=%0b done=%0b busy=%0b x=%0d y=%0d, want all 0",
               draw, done, busy, x_out, y_out);
    end
  endtask

  task automatic test_horizontal();
    dir = 1'b0; x_in = 9'd10; y_in = 8'd20; length = 9'd4; ack = 1'b1; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      x_in = 9'($urandom); y_in = 8'($urandom); length = 9'($urandom); dir = 1'($urandom);
      tests++;
      if (draw !== 1'b1 || x_out !== 9'(10 + i) || y_out !== 8'd20 || busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL horiz_pixel%0d: draw=%0b (%0d,%0d) busy=%0b done=%0b, want draw=1 (%0d,20) busy=1 done=0",
                 i, draw, x_out, y_out, busy, done, 10 + i);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (draw !== 1'b0 || done !== 1'b1 || busy !== 1'b1 || x_out !== '0 || y_out !== '0) begin
        fails++;
        $display("FAIL horiz_done%0d: draw=%0b done=%0b busy=%0b x=%0d y=%0d, want 0 1 1 0 0",
                 i, draw, done, busy, x_out, y_out);
      end
    end
    start = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL horiz_idle: busy=%0b done=%0b, want 0 0", busy, done);
    end
  endtask

  task automatic test_vertical();
    int k = 0;
    bit seen_done = 1'b0;
    dir = 1'b1; x_in = 9'd5; y_in = 8'd100; length = 9'd3; ack = 1'b0; start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) begin seen_done = 1'b1; break; end
      tests++;
      if (draw !== 1'b1 || x_out !== 9'd5 || y_out !== 8'(100 + k)) begin
        fails++;
        $display("FAIL vert_pixel%0d: draw=%0b (%0d,%0d), want draw=1 (5,%0d)",
                 k, draw, x_out, y_out, 100 + k);
      end
      ack = 1'(c % 2);
      if (draw && ack) k++;
    end
    tests++;
    if (!seen_done || k !== 3) begin
      fails++;
      $display("FAIL vert_acks: done_seen=%0b acks=%0d, want done_seen=1 acks=3", seen_done, k);
    end
    start = 1'b0; ack = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero_len();
    dir = 1'b0; x_in = 9'd7; y_in = 8'd7; length = 9'd0; ack = 1'b1; start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (draw !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
        fails++;
        $display("FAIL zero_len%0d: draw=%0b done=%0b busy=%0b, want 0 1 1", i, draw, done, busy);
      end
    end
    start = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL zero_len_idle: busy=%0b done=%0b, want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    dir = 1'b0; x_in = 9'd50; y_in = 8'd7; length = 9'd8; ack = 1'b1; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (draw !== 1'b1 || x_out !== 9'd51 || y_out !== 8'd7) begin
      fails++;
      $display("FAIL midreset_2nd: draw=%0b (%0d,%0d), want draw=1 (51,7)", draw, x_out, y_out);
    end
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({draw, done, busy, x_out, y_out} !== '0) begin
      fails++;
      $display("FAIL midreset_clear: draw=%0b done=%0b busy=%0b x=%0d y=%0d, want all 0",
               draw, done, busy, x_out, y_out);
    end
    x_in = 9'd200; y_in = 8'd3; length = 9'd2; start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (draw !== 1'b1 || x_out !== 9'(200 + i) || y_out !== 8'd3) begin
        fails++;
        $display("FAIL midreset_new%0d: draw=%0b (%0d,%0d), want draw=1 (%0d,3)",
                 i, draw, x_out, y_out, 200 + i);
      end
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || draw !== 1'b0) begin
      fails++;
      $display("FAIL midreset_done: done=%0b draw=%0b, want 1 0", done, draw);
    end
    start = 1'b0;
    @(negedge clk);
  endtask

`ifdef AXIS_LINE_DRAWER_CLIP_EN
  task automatic test_edge();
    int exp_draw[4] = '{1, 1, 0, 0};
    dir = 1'b0; x_in = 9'd318; y_in = 8'd0; length = 9'd4; ack = 1'b1; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (draw !== 1'(exp_draw[i]) || (exp_draw[i] == 1 && x_out !== 9'(318 + i))) begin
        fails++;
        $display("FAIL clip_pixel%0d: draw=%0b x=%0d, want draw=%0d x=%0d",
                 i, draw, x_out, exp_draw[i], 318 + i);
      end
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL clip_done: done=%0b, want 1", done);
    end
    start = 1'b0;
    @(negedge clk);
  endtask
`else
  task automatic test_edge();
    int exp_x[4] = '{510, 511, 0, 1};
    dir = 1'b0; x_in = 9'd510; y_in = 8'd9; length = 9'd4; ack = 1'b1; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (draw !== 1'b1 || x_out !== 9'(exp_x[i]) || y_out !== 8'd9) begin
        fails++;
        $display("FAIL wrap_pixel%0d: draw=%0b (%0d,%0d), want draw=1 (%0d,9)",
                 i, draw, x_out, y_out, exp_x[i]);
      end
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL wrap_done: done=%0b, want 1", done);
    end
    start = 1'b0;
    @(negedge clk);
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      int qx[$];
      int qy[$];
      int lx, ly, ll, budget;
      bit ld;
      bit seen_done = 1'b0;
      ld = 1'($urandom);
      lx = $urandom_range(0, (1 << X_W) - 1);
      ly = $urandom_range(0, (1 << Y_W) - 1);
      ll = $urandom_range(0, 20);
      for (int i = 0; i < ll; i++) begin
        int px, py;
        px = (lx + (ld ? 0 : i)) % (1 << X_W);
        py = (ly + (ld ? i : 0)) % (1 << Y_W);
        if (!CLIP_EN || (px < SCREEN_W && py < SCREEN_H)) begin
          qx.push_back(px);
          qy.push_back(py);
        end
      end
      dir = ld; x_in = 9'(lx); y_in = 8'(ly); length = 9'(ll); start = 1'b1;
      budget = 8 * ll + 20;
      for (int c = 0; c < budget; c++) begin
        @(negedge clk);
        x_in = 9'($urandom); y_in = 8'($urandom); length = 9'($urandom); dir = 1'($urandom);
        if (done) begin seen_done = 1'b1; break; end
        if (draw) begin
          tests++;
          if (qx.size() == 0) begin
            fails++;
            $display("FAIL rand%0d_extra: unexpected pixel (%0d,%0d), want none", n, x_out, y_out);
          end else if (x_out !== 9'(qx[0]) || y_out !== 8'(qy[0])) begin
            fails++;
            $display("FAIL rand%0d_pixel: got (%0d,%0d), want (%0d,%0d)", n, x_out, y_out, qx[0], qy[0]);
          end
        end
        ack = ($urandom_range(0, 9) < 7);
        if (draw && ack && qx.size() > 0) begin
          void'(qx.pop_front());
          void'(qy.pop_front());
        end
      end
      tests++;
      if (!seen_done || qx.size() != 0) begin
        fails++;
        $display("FAIL rand%0d_end: done_seen=%0b pixels_left=%0d, want 1 0", n, seen_done, qx.size());
      end
      start = 1'b0;
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || draw !== 1'b0) begin
        fails++;
        $display("FAIL rand%0d_idle: busy=%0b done=%0b draw=%0b, want 0 0 0", n, busy, done, draw);
      end
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_vertical();
    test_zero_len();
    test_reset_mid();
    test_edge();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
